// File: rtl/serv_rf_wide_if_pkg.sv
// Shared types and helpers for the wide register file bridge.
package serv_rf_wide_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_GRANT,
        ST_STREAM
    } state_t;

    localparam int CNT_W = 5;

    // RAM word address width: slot index plus word-within-register bits
    function automatic int rf_aw(int n_regs, int width);
        return $clog2(n_regs) + CNT_W - $clog2(width);
    endfunction

endpackage

// File: rtl/serv_rf_wide_if_if.sv
// Simple dual-port RAM bus between the bridge and the external memory.
interface serv_rf_wide_if_if #(
    parameter int WIDTH  = 8,
    parameter int N_REGS = 36
);
    import serv_rf_wide_if_pkg::*;

    localparam int AW = rf_aw(N_REGS, WIDTH);

    logic [AW-1:0]    o_raddr;
    logic             o_ren;
    logic [WIDTH-1:0] i_rdata;
    logic [AW-1:0]    o_waddr;
    logic [WIDTH-1:0] o_wdata;
    logic             o_wen;

    modport master (
        output o_raddr, o_ren, o_waddr, o_wdata, o_wen,
        input  i_rdata
    );

    modport slave (
        input  o_raddr, o_ren, o_waddr, o_wdata, o_wen,
        output i_rdata
    );

endinterface

// File: rtl/serv_rf_wide_if_wrpack.sv
// Packs serial rd bits (LSB first) into WIDTH-bit RAM write words.
module serv_rf_wide_if_wrpack #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_wen,
    input  logic             i_rd,
    input  logic             i_wrap,
    input  logic             i_skip,
    input  logic [AW-1:0]    i_waddr,
    output logic             o_wen,
    output logic [WIDTH-1:0] o_wdata,
    output logic [AW-1:0]    o_waddr
);
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] w_word;

    assign w_word = {i_rd, r_sh};

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_sh    <= '0;
            o_wen   <= 1'b0;
            o_wdata <= '0;
            o_waddr <= '0;
        end else begin
            o_wen <= i_en & i_wen & i_wrap & ~i_skip;
            if (i_en & i_wen) begin
                r_sh <= w_word[WIDTH-1:1];
                if (i_wrap) begin
                    o_wdata <= w_word;
                    o_waddr <= i_waddr;
                end
            end
        end
    end

endmodule

// File: rtl/serv_rf_wide_if.sv
// Bit-serial rs1/rs2/rd ports of SERV bridged onto a WIDTH-bit SDP RAM.
module serv_rf_wide_if
    import serv_rf_wide_if_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int N_REGS = 36,
    localparam int RW     = $clog2(N_REGS),
    localparam int AW     = rf_aw(N_REGS, WIDTH)
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_rreq,
    output logic          o_rgnt,
    input  logic [RW-1:0] i_rs1_raddr,
    input  logic [RW-1:0] i_rs2_raddr,
    input  logic [RW-1:0] i_rd_waddr,
    input  logic          i_en,
    input  logic          i_wen,
    input  logic          i_rd,
    output logic          o_rs1,
    output logic          o_rs2,
    serv_rf_wide_if_if.master ram
);
    localparam int         B     = $clog2(WIDTH);
    localparam logic [4:0] BMASK = 5'(WIDTH - 1);
    localparam logic [4:0] BPRE  = 5'(WIDTH - 2);
    localparam logic [4:0] WINC  = 5'(WIDTH);

    state_t           r_state, w_next;
    logic [4:0]       r_cnt;
    logic [RW-1:0]    r_rs1a, r_rs2a, r_rda;
    logic [WIDTH-1:0] r_rs1_sh, r_rs2_sh, r_rs1_nx;
    logic             r_cap1, r_cap2;

    logic       w_str, w_last, w_wrap, w_rd1, w_rd2;
    logic [4:0] w_b, w_nxt;

    assign w_str  = (r_state == ST_STREAM);
    assign w_b    = r_cnt & BMASK;
    assign w_nxt  = r_cnt + WINC;
    assign w_last = ((r_cnt | BMASK) == 5'd31);
    assign w_wrap = w_str & i_en & (w_b == BMASK);
    assign w_rd1  = w_str & i_en & ~w_last & (w_b == BPRE);
    assign w_rd2  = w_wrap & ~w_last;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (i_rreq) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_GRANT;
            ST_GRANT:  w_next = ST_STREAM;
            ST_STREAM: if (i_en && r_cnt == 5'd31) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rgnt      = 1'b0;
        ram.o_ren   = 1'b0;
        ram.o_raddr = '0;
        unique case (r_state)
            ST_IDLE: begin
                ram.o_ren   = i_rreq;
                ram.o_raddr = AW'({i_rs1_raddr, 5'd0} >> B);
            end
            ST_FETCH: begin
                ram.o_ren   = 1'b1;
                ram.o_raddr = AW'({r_rs2a, 5'd0} >> B);
            end
            ST_GRANT: o_rgnt = 1'b1;
            ST_STREAM: begin
                ram.o_ren = w_rd1 | w_rd2;
                if (w_rd1)
                    ram.o_raddr = AW'({r_rs1a, w_nxt} >> B);
                else if (w_rd2)
                    ram.o_raddr = AW'({r_rs2a, w_nxt} >> B);
            end
            default: ;
        endcase
    end

    // rs2 word arrives one cycle after the wrap, so it bypasses the shift reg
    assign o_rs1 = (|r_rs1a) & r_rs1_sh[0];
    assign o_rs2 = (|r_rs2a) & (r_cap2 ? ram.i_rdata[0] : r_rs2_sh[0]);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_rs1a   <= '0;
            r_rs2a   <= '0;
            r_rda    <= '0;
            r_rs1_sh <= '0;
            r_rs2_sh <= '0;
            r_rs1_nx <= '0;
            r_cap1   <= 1'b0;
            r_cap2   <= 1'b0;
        end else begin
            r_cap1 <= w_rd1;
            r_cap2 <= w_rd2;
            if (r_state == ST_IDLE && i_rreq) begin
                r_rs1a <= i_rs1_raddr;
                r_rs2a <= i_rs2_raddr;
                r_rda  <= i_rd_waddr;
            end
            if (r_state == ST_FETCH || r_cap1)
                r_rs1_nx <= ram.i_rdata;
            if (r_state == ST_GRANT) begin
                r_rs1_sh <= r_rs1_nx;
                r_rs2_sh <= ram.i_rdata;
            end
            if (w_str & i_en) begin
                r_cnt    <= r_cnt + 5'd1;
                r_rs2_sh <= r_rs2_sh >> 1;
                if (w_rd2)
                    r_rs1_sh <= r_cap1 ? ram.i_rdata : r_rs1_nx;
                else
                    r_rs1_sh <= r_rs1_sh >> 1;
            end
            if (r_cap2)
                r_rs2_sh <= (w_str & i_en) ? ram.i_rdata >> 1 : ram.i_rdata;
        end
    end

    logic             w_wen;
    logic [WIDTH-1:0] w_wdata;
    logic [AW-1:0]    w_waddr;

    serv_rf_wide_if_wrpack #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_wrpack (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_en    (w_str & i_en),
        .i_wen   (i_wen),
        .i_rd    (i_rd),
        .i_wrap  (w_b == BMASK),
        .i_skip  (r_rda == '0),
        .i_waddr (AW'({r_rda, r_cnt} >> B)),
        .o_wen   (w_wen),
        .o_wdata (w_wdata),
        .o_waddr (w_waddr)
    );

    assign ram.o_wen   = w_wen;
    assign ram.o_wdata = w_wdata;
    assign ram.o_waddr = w_waddr;

endmodule
